inst_cache: RTL

Direct-mapped, read-only instruction cache between the fetch-stage PC and a slow word-wide instruction memory port. It replaces the combinational instruction memory in the fetch stage. On a hit it returns the instruction in the same cycle. On a miss it raises `miss`, which the hazard logic ORs into `stall_f`/`stall_d`, and refills the whole line with a sequential req/ack burst.

---
 rtl/inst_cache.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with burst line refill
module inst_cache #(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [31:0]       read_data,
    output logic              miss,
    input  logic              invalidate,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES*WORDS];
    logic [IDX_W-1:0]   r_fill_idx;
    logic [TAG_W-1:0]   r_fill_tag;
    logic [OFF_W-1:0]   r_beat;
    logic               r_kill;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_start;
    logic               w_beat_ack;
    logic               w_last;
    logic               w_unused_lsbs;

    assign w_off         = address[OFF_W+1:2];
    assign w_idx         = address[OFF_W+2 +: IDX_W];
    assign w_tag         = address[ADDR_W-1 -: TAG_W];
    assign w_unused_lsbs = &address[1:0];

    // Lookup is only trusted while idle; during a refill the array is in flux
    assign w_hit      = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_start    = (r_state == S_IDLE) && !w_hit;
    assign w_beat_ack = (r_state == S_REFILL) && mem_ack;
    assign w_last     = w_beat_ack && (r_beat == LAST_BEAT);

    assign miss      = !w_hit;
    assign read_data = w_hit ? r_data[{w_idx, w_off}] : 32'h0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: any idle miss starts a refill, final ack returns to idle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next_state = S_REFILL;
            S_REFILL: if (w_last)  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Memory-side outputs: address stays on the latched line, beat selects the word
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        if (r_state == S_REFILL) begin
            mem_req  = 1'b1;
            mem_addr = {r_fill_tag, r_fill_idx, r_beat, 2'b00};
        end
    end

    // Refill bookkeeping and valid bits; r_kill remembers an invalidate seen mid-burst
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
            r_beat     <= '0;
            r_kill     <= 1'b0;
        end else begin
            if (w_start) begin
                r_fill_idx <= w_idx;
                r_fill_tag <= w_tag;
                r_beat     <= '0;
                r_kill     <= 1'b0;
            end else if (r_state == S_REFILL) begin
                if (invalidate) r_kill <= 1'b1;
                if (w_beat_ack) r_beat <= r_beat + 1'b1;
            end

            if (invalidate)
                r_valid <= '0;
            else if (w_start)
                r_valid[w_idx] <= 1'b0;
            else if (w_last && !r_kill)
                r_valid[r_fill_idx] <= 1'b1;
        end
    end

    // Data and tag storage need no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (w_beat_ack) r_data[{r_fill_idx, r_beat}] <= mem_rdata;
        if (w_last)     r_tag[r_fill_idx] <= r_fill_tag;
    end

endmodule
